// File: rtl/spm_arbiter.sv
// spm_arbiter: round-robin two-requester arbiter and command sequencer for a
// single-port 1024x16 memory with a shared bidirectional data bus. Grants are
// combinational, the memory command is registered, read data returns to the
// issuing requester three cycles after its grant, and a write is held off for
// one cycle after any read grant so the bus can turn around.
module spm_arbiter #(
    parameter int AW = 10,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req_a,
    input  logic          we_a,
    input  logic [AW-1:0] addr_a,
    input  logic [DW-1:0] wdata_a,
    input  logic          req_b,
    input  logic          we_b,
    input  logic [AW-1:0] addr_b,
    input  logic [DW-1:0] wdata_b,
    output logic          gnt_a,
    output logic          gnt_b,
    output logic          rvalid_a,
    output logic          rvalid_b,
    output logic [DW-1:0] rdata,
    output logic [AW-1:0] mem_address,
    output logic          mem_wr_en,
    output logic [AW-1:0] mem_rd,
    inout  wire  [DW-1:0] mem_data_io
);

    typedef enum logic {FAV_A = 1'b0, FAV_B = 1'b1} ptr_t;

    ptr_t          ptr_q, ptr_d;
    logic          rd_last_q, rd_last_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          wr_en_q, wr_en_d;
    logic          rd_q, rd_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic          tag1_vld_q, tag1_vld_d;
    logic          tag1_b_q, tag1_b_d;
    logic          tag2_vld_q, tag2_vld_d;
    logic          tag2_b_q, tag2_b_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          rvalid_a_q, rvalid_a_d;
    logic          rvalid_b_q, rvalid_b_d;

    logic          elig_a, elig_b;
    logic          any_gnt, g_we;
    logic [AW-1:0] g_addr;
    logic [DW-1:0] g_wdata;

    // Eligibility and round-robin grant; a write right after a read grant is
    // held off because the memory owns the bus two cycles after that read.
    always_comb begin
        elig_a = req_a & ~(we_a & rd_last_q) & ~reset;
        elig_b = req_b & ~(we_b & rd_last_q) & ~reset;
        gnt_a  = elig_a & ((ptr_q == FAV_A) | ~elig_b);
        gnt_b  = elig_b & ((ptr_q == FAV_B) | ~elig_a);
    end

    // Mux the granted command and compute the next register state.
    always_comb begin
        any_gnt = gnt_a | gnt_b;
        g_we    = gnt_b ? we_b    : we_a;
        g_addr  = gnt_b ? addr_b  : addr_a;
        g_wdata = gnt_b ? wdata_b : wdata_a;

        ptr_d = ptr_q;
        if (gnt_a) ptr_d = FAV_B;
        else if (gnt_b) ptr_d = FAV_A;

        rd_last_d = any_gnt & ~g_we;
        addr_d    = any_gnt ? g_addr  : addr_q;
        wdata_d   = any_gnt ? g_wdata : wdata_q;
        wr_en_d   = any_gnt & g_we;
        rd_d      = any_gnt & ~g_we;

        // Tag follows the read while the memory fetches and drives the bus.
        tag1_vld_d = any_gnt & ~g_we;
        tag1_b_d   = gnt_b;
        tag2_vld_d = tag1_vld_q;
        tag2_b_d   = tag1_b_q;

        rdata_d    = tag2_vld_q ? mem_data_io : rdata_q;
        rvalid_a_d = tag2_vld_q & ~tag2_b_q;
        rvalid_b_d = tag2_vld_q & tag2_b_q;
    end

    // All state registers; reset also discards reads still in the tag pipeline.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q      <= FAV_A;
            rd_last_q  <= 1'b0;
            addr_q     <= '0;
            wr_en_q    <= 1'b0;
            rd_q       <= 1'b0;
            wdata_q    <= '0;
            tag1_vld_q <= 1'b0;
            tag1_b_q   <= 1'b0;
            tag2_vld_q <= 1'b0;
            tag2_b_q   <= 1'b0;
            rdata_q    <= '0;
            rvalid_a_q <= 1'b0;
            rvalid_b_q <= 1'b0;
        end else begin
            ptr_q      <= ptr_d;
            rd_last_q  <= rd_last_d;
            addr_q     <= addr_d;
            wr_en_q    <= wr_en_d;
            rd_q       <= rd_d;
            wdata_q    <= wdata_d;
            tag1_vld_q <= tag1_vld_d;
            tag1_b_q   <= tag1_b_d;
            tag2_vld_q <= tag2_vld_d;
            tag2_b_q   <= tag2_b_d;
            rdata_q    <= rdata_d;
            rvalid_a_q <= rvalid_a_d;
            rvalid_b_q <= rvalid_b_d;
        end
    end

    assign mem_address = addr_q;
    assign mem_wr_en   = wr_en_q;
    assign mem_rd      = {{(AW-1){1'b0}}, rd_q};
    assign rdata       = rdata_q;
    assign rvalid_a    = rvalid_a_q;
    assign rvalid_b    = rvalid_b_q;

    // Drive the shared bus only while a write command is presented.
    assign mem_data_io = wr_en_q ? wdata_q : {DW{1'bz}};

endmodule

// File: tb/tb_spm_arbiter.sv
// Directed testbench for spm_arbiter with a behavioural single-port memory
// that registers commands and drives the shared bus the cycle after a read.
module tb_spm_arbiter;

    logic        clk;
    logic        reset;
    logic        req_a, we_a, req_b, we_b;
    logic [9:0]  addr_a, addr_b;
    logic [15:0] wdata_a, wdata_b;
    logic        gnt_a, gnt_b, rvalid_a, rvalid_b;
    logic [15:0] rdata;
    logic [9:0]  mem_address;
    logic        mem_wr_en;
    logic [9:0]  mem_rd;
    wire  [15:0] mem_data_io;

    int checks = 0;
    int errors = 0;

    logic [15:0] mem [0:1023];
    logic        mem_drv = 1'b0;
    logic [15:0] mem_dout = 16'h0000;
    logic        bd_we = 1'b0;
    logic [9:0]  bd_addr = 10'h000;
    logic [15:0] bd_data = 16'h0000;

    spm_arbiter #(.AW(10), .DW(16)) dut (
        .clk(clk), .reset(reset),
        .req_a(req_a), .we_a(we_a), .addr_a(addr_a), .wdata_a(wdata_a),
        .req_b(req_b), .we_b(we_b), .addr_b(addr_b), .wdata_b(wdata_b),
        .gnt_a(gnt_a), .gnt_b(gnt_b), .rvalid_a(rvalid_a), .rvalid_b(rvalid_b),
        .rdata(rdata), .mem_address(mem_address), .mem_wr_en(mem_wr_en),
        .mem_rd(mem_rd), .mem_data_io(mem_data_io)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: write at the edge ending the wr_en cycle, drive read data
    // during the cycle after the read strobe.
    assign mem_data_io = mem_drv ? mem_dout : 16'bz;
    always @(posedge clk) begin
        if (bd_we) mem[bd_addr] <= bd_data;
        else if (mem_wr_en) mem[mem_address] <= mem_data_io;
        mem_drv <= mem_rd[0];
        if (mem_rd[0]) mem_dout <= mem[mem_address];
    end

    // Bus monitor: memory and arbiter must never drive together.
    always @(negedge clk) begin
        if (!reset) begin
            checks++;
            if (mem_drv && mem_wr_en) begin
                errors++;
                $display("FAIL bus_contention t=%0t mem_wr_en=%b mem_drv=%b", $time, mem_wr_en, mem_drv);
            end else if (mem_drv && (mem_data_io !== mem_dout)) begin
                errors++;
                $display("FAIL bus_read_value t=%0t got=%h exp=%h", $time, mem_data_io, mem_dout);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req_a = 0; we_a = 0; addr_a = '0; wdata_a = '0;
        req_b = 0; we_b = 0; addr_b = '0; wdata_b = '0;
    endtask

    task automatic preload(input logic [9:0] a, input logic [15:0] d);
        bd_we = 1'b1; bd_addr = a; bd_data = d;
        @(posedge clk);
        #1;
        bd_we = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        repeat (2) cyc();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            req_a = (i == 1); req_b = (i == 2);
            #1;
            checks++;
            if ({gnt_a, gnt_b, rvalid_a, rvalid_b, mem_wr_en} !== 5'b0 ||
                mem_rd !== 10'h000 || mem_address !== 10'h000 || rdata !== 16'h0000) begin
                errors++;
                $display("FAIL reset_hold cyc=%0d gnt=%b%b rv=%b%b we=%b rd=%h ad=%h rdata=%h exp all 0",
                         i, gnt_a, gnt_b, rvalid_a, rvalid_b, mem_wr_en, mem_rd, mem_address, rdata);
            end
        end
        for (int i = 0; i < 3; i++) begin
            cyc();
            reset = 1'b0;
            idle_inputs();
            #1;
            checks++;
            if ({gnt_a, gnt_b, rvalid_a, rvalid_b, mem_wr_en} !== 5'b0 ||
                mem_rd !== 10'h000 || mem_address !== 10'h000 || rdata !== 16'h0000) begin
                errors++;
                $display("FAIL reset_release cyc=%0d gnt=%b%b rv=%b%b we=%b rd=%h ad=%h rdata=%h exp all 0",
                         i, gnt_a, gnt_b, rvalid_a, rvalid_b, mem_wr_en, mem_rd, mem_address, rdata);
            end
        end
    endtask

    task automatic test_write_read();
        do_reset();
        cyc();  // cycle 0: write
        req_a = 1; we_a = 1; addr_a = 10'h005; wdata_a = 16'hA5A5;
        #1;
        checks++;
        if ({gnt_a, gnt_b} !== 2'b10) begin
            errors++; $display("FAIL wr_grant got=%b%b exp=10", gnt_a, gnt_b);
        end
        cyc();  // cycle 1: read same address
        we_a = 0;
        #1;
        checks++;
        if ({gnt_a, gnt_b} !== 2'b10) begin
            errors++; $display("FAIL raw_grant got=%b%b exp=10", gnt_a, gnt_b);
        end
        checks++;
        if (mem_wr_en !== 1'b1 || mem_address !== 10'h005 || mem_data_io !== 16'hA5A5) begin
            errors++;
            $display("FAIL wr_cmd we=%b ad=%h bus=%h exp 1 005 a5a5", mem_wr_en, mem_address, mem_data_io);
        end
        for (int c = 2; c <= 5; c++) begin
            cyc();
            idle_inputs();
            #1;
            if (c == 2) begin
                checks++;
                if (mem_rd !== 10'h001 || mem_wr_en !== 1'b0 || mem_address !== 10'h005) begin
                    errors++;
                    $display("FAIL rd_cmd rd=%h we=%b ad=%h exp 001 0 005", mem_rd, mem_wr_en, mem_address);
                end
            end
            checks++;
            if ({rvalid_a, rvalid_b} !== ((c == 4) ? 2'b10 : 2'b00)) begin
                errors++;
                $display("FAIL wr_rd_rvalid cyc=%0d got=%b%b exp=%b", c, rvalid_a, rvalid_b, (c == 4));
            end
            if (c == 4) begin
                checks++;
                if (rdata !== 16'hA5A5) begin
                    errors++; $display("FAIL wr_rd_data got=%h exp=a5a5", rdata);
                end
            end
        end
    endtask

    task automatic test_round_robin();
        idle_inputs();
        reset = 1'b1;
        preload(10'h010, 16'h1111);
        preload(10'h020, 16'h2222);
        do_reset();
        for (int k = 0; k <= 10; k++) begin
            logic [1:0] eg, er;
            cyc();
            req_a = (k < 8); req_b = (k < 8);
            we_a = 0; we_b = 0; addr_a = 10'h010; addr_b = 10'h020;
            #1;
            eg = (k < 8) ? ((k % 2 == 0) ? 2'b10 : 2'b01) : 2'b00;
            er = (k >= 3) ? (((k - 3) % 2 == 0) ? 2'b10 : 2'b01) : 2'b00;
            checks++;
            if ({gnt_a, gnt_b} !== eg) begin
                errors++; $display("FAIL rr_grant cyc=%0d got=%b%b exp=%b", k, gnt_a, gnt_b, eg);
            end
            checks++;
            if ({rvalid_a, rvalid_b} !== er) begin
                errors++; $display("FAIL rr_rvalid cyc=%0d got=%b%b exp=%b", k, rvalid_a, rvalid_b, er);
            end
            if (k >= 3) begin
                checks++;
                if (rdata !== (er[1] ? 16'h1111 : 16'h2222)) begin
                    errors++;
                    $display("FAIL rr_rdata cyc=%0d got=%h exp=%h", k, rdata, er[1] ? 16'h1111 : 16'h2222);
                end
            end
        end
    endtask

    task automatic test_turnaround();
        do_reset();
        cyc();  // cycle 0: A read
        req_a = 1; we_a = 0; addr_a = 10'h000;
        #1;
        checks++;
        if ({gnt_a, gnt_b} !== 2'b10) begin
            errors++; $display("FAIL ta_read_grant got=%b%b exp=10", gnt_a, gnt_b);
        end
        cyc();  // cycle 1: B write blocked
        req_a = 0;
        req_b = 1; we_b = 1; addr_b = 10'h030; wdata_b = 16'h1234;
        #1;
        checks++;
        if ({gnt_a, gnt_b} !== 2'b00) begin
            errors++; $display("FAIL ta_blocked got=%b%b exp=00", gnt_a, gnt_b);
        end
        cyc();  // cycle 2: B write granted
        #1;
        checks++;
        if ({gnt_a, gnt_b} !== 2'b01) begin
            errors++; $display("FAIL ta_write_grant got=%b%b exp=01", gnt_a, gnt_b);
        end
        cyc();  // cycle 3
        idle_inputs();
        #1;
        checks++;
        if (mem_wr_en !== 1'b1 || mem_data_io !== 16'h1234 || rvalid_a !== 1'b1) begin
            errors++;
            $display("FAIL ta_wr_cmd we=%b bus=%h rva=%b exp 1 1234 1", mem_wr_en, mem_data_io, rvalid_a);
        end
        cyc();  // cycle 4: read back
        req_a = 1; we_a = 0; addr_a = 10'h030;
        #1;
        checks++;
        if ({gnt_a, gnt_b} !== 2'b10) begin
            errors++; $display("FAIL ta_rb_grant got=%b%b exp=10", gnt_a, gnt_b);
        end
        for (int c = 5; c <= 7; c++) begin
            cyc();
            idle_inputs();
            #1;
        end
        checks++;
        if (rvalid_a !== 1'b1 || rvalid_b !== 1'b0 || rdata !== 16'h1234) begin
            errors++;
            $display("FAIL ta_readback rv=%b%b rdata=%h exp 10 1234", rvalid_a, rvalid_b, rdata);
        end
    endtask

    task automatic test_blocked_write_pointer();
        logic [1:0]  eg [0:8];
        logic [1:0]  er [0:8];
        logic [15:0] ed [0:8];
        idle_inputs();
        reset = 1'b1;
        preload(10'h020, 16'h0B20);
        preload(10'h021, 16'h0B21);
        preload(10'h022, 16'h0B22);
        do_reset();
        eg = '{2'b01, 2'b01, 2'b00, 2'b10, 2'b01, 2'b10, 2'b00, 2'b00, 2'b00};
        er = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00, 2'b01, 2'b10};
        ed = '{16'h0, 16'h0, 16'h0, 16'h0B20, 16'h0B21, 16'h0, 16'h0, 16'h0B22, 16'h5A5A};
        for (int c = 0; c <= 8; c++) begin
            cyc();
            idle_inputs();
            case (c)
                0: begin req_b = 1; addr_b = 10'h020; end
                1: begin req_b = 1; addr_b = 10'h021;
                         req_a = 1; we_a = 1; addr_a = 10'h050; wdata_a = 16'h5A5A; end
                2: begin req_a = 1; we_a = 1; addr_a = 10'h050; wdata_a = 16'h5A5A; end
                3: begin req_b = 1; addr_b = 10'h022;
                         req_a = 1; we_a = 1; addr_a = 10'h050; wdata_a = 16'h5A5A; end
                4: begin req_b = 1; addr_b = 10'h022; end
                5: begin req_a = 1; addr_a = 10'h050; end
                default: ;
            endcase
            #1;
            checks++;
            if ({gnt_a, gnt_b} !== eg[c]) begin
                errors++; $display("FAIL bw_grant cyc=%0d got=%b%b exp=%b", c, gnt_a, gnt_b, eg[c]);
            end
            checks++;
            if ({rvalid_a, rvalid_b} !== er[c]) begin
                errors++; $display("FAIL bw_rvalid cyc=%0d got=%b%b exp=%b", c, rvalid_a, rvalid_b, er[c]);
            end
            if (er[c] != 2'b00) begin
                checks++;
                if (rdata !== ed[c]) begin
                    errors++; $display("FAIL bw_rdata cyc=%0d got=%h exp=%h", c, rdata, ed[c]);
                end
            end
        end
    endtask

    task automatic test_reset_midop();
        idle_inputs();
        reset = 1'b1;
        preload(10'h060, 16'h6666);
        do_reset();
        cyc();  // cycle 0: read granted
        req_a = 1; we_a = 0; addr_a = 10'h060;
        #1;
        checks++;
        if ({gnt_a, gnt_b} !== 2'b10) begin
            errors++; $display("FAIL rm_grant got=%b%b exp=10", gnt_a, gnt_b);
        end
        cyc();  // cycle 1: reset asserted
        idle_inputs();
        reset = 1'b1;
        for (int c = 2; c <= 5; c++) begin
            cyc();
            reset = 1'b0;
            #1;
            checks++;
            if ({rvalid_a, rvalid_b, mem_wr_en} !== 3'b000 || mem_rd !== 10'h000) begin
                errors++;
                $display("FAIL rm_discard cyc=%0d rv=%b%b we=%b rd=%h exp 0", c, rvalid_a, rvalid_b, mem_wr_en, mem_rd);
            end
        end
        cyc();  // cycle 6: write granted
        req_a = 1; we_a = 1; addr_a = 10'h070; wdata_a = 16'h7777;
        #1;
        checks++;
        if (gnt_a !== 1'b1) begin
            errors++; $display("FAIL rm_wr_grant got=%b exp=1", gnt_a);
        end
        cyc();  // cycle 7: reset while write on bus
        idle_inputs();
        reset = 1'b1;
        #1;
        checks++;
        if (mem_wr_en !== 1'b1) begin
            errors++; $display("FAIL rm_wr_cmd got=%b exp=1", mem_wr_en);
        end
        cyc();  // cycle 8: bus released
        reset = 1'b0;
        #1;
        checks++;
        if (mem_wr_en !== 1'b0 || mem_address !== 10'h000) begin
            errors++; $display("FAIL rm_bus_release we=%b ad=%h exp 0 000", mem_wr_en, mem_address);
        end
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;
        test_reset();
        test_write_read();
        test_round_robin();
        test_turnaround();
        test_blocked_write_pointer();
        test_reset_midop();
        cyc();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
